syncount_param: RTL

- Parametrised synchronous counter; generalises the fixed 4-bit wrap-at-all-ones up-counter.
- Adds: configurable width, runtime terminal limit, up/down direction, parallel load, wrap or saturate mode, clock-enable prescaler, compare-match and event outputs.
- Used as the common timebase/event counter for datapath and display-scan blocks.

---
 rtl/syncount_param.sv | 111 +++++++++++
 1 files changed

// File: rtl/syncount_param.sv
// syncount_param: parametrised synchronous timebase/event counter.
//   Counts 0..limit up or down, with wrap or saturate at the boundary,
//   parallel load and a clock-enable prescaler. Also produces a wrap
//   pulse and boundary/compare flags.
// Parameters:
//   WIDTH    - counter width in bits (>=2)
//   PRESCALE - enabled cycles per count step (>=1)
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   en        - count enable (prescaler advances only when high)
//   up        - 1 = increment, 0 = decrement
//   sat       - 0 = wrap at boundary, 1 = saturate at boundary
//   load      - parallel load strobe (overrides en)
//   load_val  - value loaded on load
//   limit     - terminal value, count range 0..limit
//   cmp_val   - compare value
//   q         - registered count
//   wrap      - registered one-cycle pulse when q takes a wrapped value
//   at_bound  - registered, q==limit (up) or q==0 (down)
//   cmp_match - registered, q==cmp_val
module syncount_param #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             at_bound,
  output logic             cmp_match
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    ps;
  logic [PW-1:0]    ps_next;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic             step;

  // Next-state: load beats counting; a step fires on the last prescaler phase
  always_comb begin
    ps_next   = ps;
    q_next    = q;
    wrap_next = 1'b0;
    step      = 1'b0;
    if (load) begin
      ps_next = '0;
      q_next  = load_val;
    end else if (en) begin
      if (ps == PS_LAST) begin
        ps_next = '0;
        step    = 1'b1;
      end else begin
        ps_next = ps + PW'(1);
      end
    end

    if (step) begin
      if (up) begin
        if (q < limit) begin
          q_next = q + WIDTH'(1);
        end else if (sat) begin
          q_next = limit;
        end else begin
          q_next    = '0;
          wrap_next = 1'b1;
        end
      end else begin
        // An out-of-range value (e.g. loaded above limit) snaps back to limit
        if (q > limit) begin
          q_next = limit;
        end else if (q != '0) begin
          q_next = q - WIDTH'(1);
        end else if (sat) begin
          q_next = '0;
        end else begin
          q_next    = limit;
          wrap_next = 1'b1;
        end
      end
    end
  end

  // Flags are derived from q_next so they line up with q without latency
  always_ff @(posedge clk) begin
    if (rst) begin
      ps        <= '0;
      q         <= '0;
      wrap      <= 1'b0;
      at_bound  <= 1'b0;
      cmp_match <= 1'b0;
    end else begin
      ps        <= ps_next;
      q         <= q_next;
      wrap      <= wrap_next;
      at_bound  <= up ? (q_next == limit) : (q_next == '0);
      cmp_match <= (q_next == cmp_val);
    end
  end

endmodule
